// File: rtl/wave_dispatcher_pkg.sv
// Shared definitions for the wave dispatcher: FSM state encodings and the
// SIMD state code that the program counter logic also understands.
package wave_dispatcher_pkg;

    typedef enum logic [1:0] {
        DISP_IDLE = 2'd0,
        DISP_RUN  = 2'd1,
        DISP_DONE = 2'd2
    } disp_state_e;

    // SIMD unit state code while a wave is executing (used by the PC).
    localparam logic [2:0] EXECUTE = 3'b101;

endpackage

// File: rtl/wave_dispatcher_simd_slot_arbiter.sv
// Combinational priority encoder: picks the lowest-index free SIMD slot.
// grant_o is one-hot (or zero when nothing is free); valid_o flags a grant.
module simd_slot_arbiter #(
    parameter int NUM_SIMD = 4
) (
    input  logic [NUM_SIMD-1:0] free_i,
    output logic [NUM_SIMD-1:0] grant_o,
    output logic                valid_o
);

    // Scan from the top down so the lowest free index is the last one written.
    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        for (int i = NUM_SIMD - 1; i >= 0; i--) begin
            if (free_i[i]) begin
                grant_o    = '0;
                grant_o[i] = 1'b1;
                valid_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wave_dispatcher.sv
// Wave dispatcher: hands the waves of a kernel launch to SIMD units one per
// cycle, tracks their retirement and pulses kernel_done once all are retired.
module wave_dispatcher
    import wave_dispatcher_pkg::*;
#(
    parameter int NUM_SIMD      = 4,
    parameter int WAVE_ID_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              kernel_start,
    input  logic [WAVE_ID_WIDTH-1:0]          num_waves,
    input  logic [NUM_SIMD-1:0]               simd_done,
    output logic [NUM_SIMD-1:0]               simd_enable,
    output logic [NUM_SIMD-1:0]               dispatch_new_wave,
    output logic [NUM_SIMD*WAVE_ID_WIDTH-1:0] wave_id,
    output logic                              busy,
    output logic                              kernel_done
);

    disp_state_e                                  state_q, state_d;
    logic [NUM_SIMD-1:0]                          enable_q, enable_d;
    logic [NUM_SIMD-1:0]                          pulse_q, pulse_d;
    logic [NUM_SIMD-1:0][WAVE_ID_WIDTH-1:0]       wave_id_q, wave_id_d;
    logic                                         busy_q, busy_d;
    logic                                         done_q, done_d;
    logic [WAVE_ID_WIDTH-1:0]                     num_q, num_d;
    logic [WAVE_ID_WIDTH-1:0]                     disp_q, disp_d;
    logic [WAVE_ID_WIDTH-1:0]                     ret_q, ret_d;

    logic [NUM_SIMD-1:0]                          retire_mask;
    logic [NUM_SIMD-1:0]                          grant;
    logic                                         grant_vld;

    function automatic logic [WAVE_ID_WIDTH-1:0] popcount(input logic [NUM_SIMD-1:0] v);
        logic [WAVE_ID_WIDTH-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_SIMD; i++) begin
            cnt = cnt + WAVE_ID_WIDTH'(v[i]);
        end
        return cnt;
    endfunction

    // Only done pulses on occupied slots count as retirements.
    assign retire_mask = simd_done & enable_q;

    // Eligibility is based on occupancy at the start of the cycle, so a slot
    // retired this cycle is only offered again on the next one.
    simd_slot_arbiter #(
        .NUM_SIMD (NUM_SIMD)
    ) u_arbiter (
        .free_i  (~enable_q),
        .grant_o (grant),
        .valid_o (grant_vld)
    );

    // Next-state and registered-output logic for the launch FSM.
    always_comb begin
        state_d   = state_q;
        enable_d  = enable_q;
        pulse_d   = '0;
        wave_id_d = wave_id_q;
        done_d    = 1'b0;
        num_d     = num_q;
        disp_d    = disp_q;
        ret_d     = ret_q;

        unique case (state_q)
            DISP_IDLE: begin
                if (kernel_start) begin
                    num_d   = num_waves;
                    disp_d  = '0;
                    ret_d   = '0;
                    state_d = DISP_RUN;
                end
            end
            DISP_RUN: begin
                enable_d = enable_q & ~retire_mask;
                ret_d    = ret_q + popcount(retire_mask);
                if (grant_vld && (disp_q < num_q)) begin
                    enable_d = enable_d | grant;
                    pulse_d  = grant;
                    disp_d   = disp_q + WAVE_ID_WIDTH'(1);
                    for (int i = 0; i < NUM_SIMD; i++) begin
                        if (grant[i]) begin
                            wave_id_d[i] = disp_q;
                        end
                    end
                end
                // A wave dispatched this cycle cannot retire this cycle, so
                // checking the pre-update dispatch count is sufficient.
                if ((disp_q == num_q) && (ret_d == num_q)) begin
                    state_d = DISP_DONE;
                end
            end
            DISP_DONE: begin
                done_d  = 1'b1;
                state_d = DISP_IDLE;
            end
            default: begin
                state_d = DISP_IDLE;
            end
        endcase

        busy_d = (state_d != DISP_IDLE);
    end

    // State, slot and counter registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DISP_IDLE;
            enable_q  <= '0;
            pulse_q   <= '0;
            wave_id_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            num_q     <= '0;
            disp_q    <= '0;
            ret_q     <= '0;
        end else begin
            state_q   <= state_d;
            enable_q  <= enable_d;
            pulse_q   <= pulse_d;
            wave_id_q <= wave_id_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            num_q     <= num_d;
            disp_q    <= disp_d;
            ret_q     <= ret_d;
        end
    end

    assign simd_enable       = enable_q;
    assign dispatch_new_wave = pulse_q;
    assign wave_id           = wave_id_q;
    assign busy              = busy_q;
    assign kernel_done       = done_q;

endmodule

// File: tb/tb_wave_dispatcher.sv
// Directed bench for wave_dispatcher with a behavioural launch model and
// literal spot checks of the expected pulse timing.
module tb_wave_dispatcher;

    localparam int NS = 4;
    localparam int W  = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            kernel_start = 1'b0;
    logic [W-1:0]    num_waves = '0;
    logic [NS-1:0]   simd_done = '0;
    logic [NS-1:0]   simd_enable;
    logic [NS-1:0]   dispatch_new_wave;
    logic [NS*W-1:0] wave_id;
    logic            busy;
    logic            kernel_done;

    int checks   = 0;
    int failures = 0;

    wave_dispatcher #(.NUM_SIMD(NS), .WAVE_ID_WIDTH(W)) dut (
        .clk               (clk),
        .rst               (rst),
        .kernel_start      (kernel_start),
        .num_waves         (num_waves),
        .simd_done         (simd_done),
        .simd_enable       (simd_enable),
        .dispatch_new_wave (dispatch_new_wave),
        .wave_id           (wave_id),
        .busy              (busy),
        .kernel_done       (kernel_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 = idle, 1 = launch running, 2 = finishing
    int   m_phase = 0;
    int   m_nw = 0, m_disp = 0, m_ret = 0;
    bit   m_busy [NS];
    int   m_wid  [NS];
    logic [NS-1:0] e_pulse = '0;
    logic e_busy = 1'b0, e_kdone = 1'b0;
    int   first_free, disp_before;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = 0; m_nw = 0; m_disp = 0; m_ret = 0;
            for (int i = 0; i < NS; i++) begin m_busy[i] = 0; m_wid[i] = 0; end
            e_pulse = '0; e_busy = 1'b0; e_kdone = 1'b0;
        end else begin
            e_pulse = '0;
            e_kdone = 1'b0;
            if (m_phase == 0) begin
                if (kernel_start) begin
                    m_nw = int'(num_waves); m_disp = 0; m_ret = 0; m_phase = 1;
                end
            end else if (m_phase == 1) begin
                first_free = -1;
                for (int i = 0; i < NS; i++)
                    if (!m_busy[i] && first_free < 0) first_free = i;
                disp_before = m_disp;
                for (int i = 0; i < NS; i++)
                    if (simd_done[i] && m_busy[i]) begin m_busy[i] = 0; m_ret++; end
                if (m_disp < m_nw && first_free >= 0) begin
                    m_busy[first_free]  = 1;
                    e_pulse[first_free] = 1'b1;
                    m_wid[first_free]   = m_disp;
                    m_disp++;
                end
                if (disp_before == m_nw && m_ret == m_nw) m_phase = 2;
            end else begin
                e_kdone = 1'b1;
                m_phase = 0;
            end
            e_busy = (m_phase != 0);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    logic [NS-1:0]   exp_en;
    logic [NS*W-1:0] exp_wid;
    always @(negedge clk) begin
        for (int i = 0; i < NS; i++) begin
            exp_en[i] = m_busy[i];
            exp_wid[i*W +: W] = W'(m_wid[i]);
        end
        chk("model_enable", 64'(simd_enable), 64'(exp_en));
        chk("model_pulse", 64'(dispatch_new_wave), 64'(e_pulse));
        chk("model_wave_id", 64'(wave_id), 64'(exp_wid));
        chk("model_busy", 64'(busy), 64'(e_busy));
        chk("model_kdone", 64'(kernel_done), 64'(e_kdone));
    end

    // Apply inputs, then let one rising edge sample them.
    task automatic drive(input logic ks, input logic [W-1:0] nw, input logic [NS-1:0] dn);
        kernel_start = ks;
        num_waves    = nw;
        simd_done    = dn;
        @(negedge clk);
    endtask

    initial begin
        // 1. reset held with kernel_start asserted
        #1 rst = 1'b0;
        kernel_start = 1'b1;
        num_waves    = 16'd5;
        repeat (3) @(negedge clk);
        chk("rst_enable", 64'(simd_enable), 64'h0);
        chk("rst_pulse", 64'(dispatch_new_wave), 64'h0);
        chk("rst_wave_id", 64'(wave_id), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_kdone", 64'(kernel_done), 64'h0);
        kernel_start = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);
        drive(0, 0, 4'b0000);
        chk("post_rst_busy", 64'(busy), 64'h0);

        // 2. three waves, no completions
        drive(1, 3, 4'b0000);
        chk("t2_busy", 64'(busy), 64'h1);
        chk("t2_no_pulse_yet", 64'(dispatch_new_wave), 64'h0);
        drive(0, 0, 4'b0000);
        chk("t2_pulse0", 64'(dispatch_new_wave), 64'h1);
        drive(0, 0, 4'b0000);
        chk("t2_pulse1", 64'(dispatch_new_wave), 64'h2);
        chk("t2_wid1", 64'(wave_id[1*W +: W]), 64'd1);
        drive(0, 0, 4'b0000);
        chk("t2_pulse2", 64'(dispatch_new_wave), 64'h4);
        chk("t2_enable", 64'(simd_enable), 64'h7);
        chk("t2_wid2", 64'(wave_id[2*W +: W]), 64'd2);
        drive(0, 0, 4'b0000);
        drive(0, 0, 4'b0000);
        chk("t2_no_kdone", 64'(kernel_done), 64'h0);
        drive(0, 0, 4'b0111);
        drive(0, 0, 4'b0000);
        chk("t2_kdone", 64'(kernel_done), 64'h1);
        drive(0, 0, 4'b0000);
        chk("t2_kdone_fall", 64'(kernel_done), 64'h0);

        // 3. six waves with slot reuse
        drive(1, 6, 4'b0000);
        repeat (4) drive(0, 0, 4'b0000);
        chk("t3_full", 64'(simd_enable), 64'hF);
        drive(0, 0, 4'b0100);
        chk("t3_no_same_cycle", 64'(dispatch_new_wave), 64'h0);
        chk("t3_freed", 64'(simd_enable), 64'hB);
        drive(0, 0, 4'b0000);
        chk("t3_reuse2", 64'(dispatch_new_wave), 64'h4);
        chk("t3_wid2", 64'(wave_id[2*W +: W]), 64'd4);
        drive(0, 0, 4'b0001);
        drive(0, 0, 4'b0000);
        chk("t3_reuse0", 64'(dispatch_new_wave), 64'h1);
        chk("t3_wid0", 64'(wave_id[0 +: W]), 64'd5);
        drive(0, 0, 4'b1111);
        drive(0, 0, 4'b0000);
        chk("t3_kdone", 64'(kernel_done), 64'h1);
        drive(0, 0, 4'b0000);

        // 4. four in flight, all retire together
        drive(1, 4, 4'b0000);
        repeat (4) drive(0, 0, 4'b0000);
        drive(0, 0, 4'b1111);
        chk("t4_cleared", 64'(simd_enable), 64'h0);
        chk("t4_busy_done", 64'(busy), 64'h1);
        drive(0, 0, 4'b0000);
        chk("t4_kdone", 64'(kernel_done), 64'h1);
        chk("t4_idle", 64'(busy), 64'h0);
        drive(0, 0, 4'b0000);
        chk("t4_kdone_one", 64'(kernel_done), 64'h0);

        // 5. empty launch
        drive(1, 0, 4'b0000);
        drive(0, 0, 4'b0000);
        chk("t5_n1_kdone", 64'(kernel_done), 64'h0);
        drive(0, 0, 4'b0000);
        chk("t5_n2_kdone", 64'(kernel_done), 64'h1);
        chk("t5_no_pulse", 64'(dispatch_new_wave), 64'h0);
        drive(0, 0, 4'b0000);

        // 6. ignored start / stray done, then reset mid-launch
        drive(1, 3, 4'b0000);
        drive(0, 0, 4'b0000);
        drive(1, 2, 4'b1000);
        chk("t6_pulse1", 64'(dispatch_new_wave), 64'h2);
        drive(0, 0, 4'b0000);
        drive(0, 0, 4'b0011);
        drive(0, 0, 4'b0000);
        chk("t6_still_busy", 64'(busy), 64'h1);
        chk("t6_enable", 64'(simd_enable), 64'h4);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_enable", 64'(simd_enable), 64'h0);
        chk("t6_rst_busy", 64'(busy), 64'h0);
        #1 rst = 1'b1;
        @(negedge clk);
        repeat (3) drive(0, 0, 4'b0000);
        chk("t6_no_kdone", 64'(kernel_done), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
